// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU main controller.
// Sequences the datapath latches (PC, IR, A/B, ALU-out, MDR) and the memory and
// register-file strobes through IF/ID/EXE/MEM/WB, stalls on mem_ready in IF and
// MEM, and counts retired instructions. OP_HALT parks the FSM until reset.
module mc_ctrl_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        ab_write,
  output logic        aluout_write,
  output logic        mdr_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] instr_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] instr_cnt_reg;
  logic        retire;

  // State register and retired-instruction counter; reset aborts any instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IF;
      instr_cnt_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        instr_cnt_reg <= instr_cnt_reg + 32'd1;
      end
    end
  end

  // Next-state, retire and datapath control decode; reset silences everything.
  always_comb begin
    state_next   = state_reg;
    retire       = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    ir_write     = 1'b0;
    ab_write     = 1'b0;
    aluout_write = 1'b0;
    mdr_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;

    case (state_reg)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_ID;
        end
      end
      S_ID: begin
        // A/B latch and branch-target precompute happen for every opcode.
        ab_write     = 1'b1;
        aluout_write = 1'b1;
        alu_src_b    = 2'b11;
        case (op)
          OP_J: begin
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            retire     = 1'b1;
            state_next = S_IF;
          end
          OP_HALT: begin
            state_next = S_HALT;
          end
          OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: begin
            state_next = S_EXE;
          end
          default: begin
            retire     = 1'b1;
            state_next = S_IF;
          end
        endcase
      end
      S_EXE: begin
        alu_src_a    = 1'b1;
        aluout_write = 1'b1;
        case (op)
          OP_RTYPE: begin
            alu_op     = 2'b10;
            state_next = S_WB;
          end
          OP_ADDI: begin
            alu_src_b  = 2'b10;
            state_next = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b  = 2'b10;
            state_next = S_MEM;
          end
          OP_BEQ: begin
            // Keep the precomputed branch target in ALU-out; compare A-B here.
            alu_op       = 2'b01;
            aluout_write = 1'b0;
            pc_write     = zero;
            pc_src       = 2'b01;
            retire       = 1'b1;
            state_next   = S_IF;
          end
          default: begin
            state_next = S_IF;
          end
        endcase
      end
      S_MEM: begin
        iord = 1'b1;
        if (op == OP_LW) begin
          mem_read = 1'b1;
          if (mem_ready) begin
            mdr_write  = 1'b1;
            state_next = S_WB;
          end
        end else if (op == OP_SW) begin
          mem_write = 1'b1;
          if (mem_ready) begin
            retire     = 1'b1;
            state_next = S_IF;
          end
        end else begin
          state_next = S_IF;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op == OP_RTYPE);
        mem_to_reg = (op == OP_LW);
        retire     = 1'b1;
        state_next = S_IF;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IF;
      end
    endcase

    if (reset) begin
      state_next   = S_IF;
      retire       = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 2'b00;
      ir_write     = 1'b0;
      ab_write     = 1'b0;
      aluout_write = 1'b0;
      mdr_write    = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b00;
      alu_op       = 2'b00;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      iord         = 1'b0;
      reg_write    = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
    end
  end

  assign state     = state_reg;
  assign halted    = (state_reg == S_HALT);
  assign instr_cnt = instr_cnt_reg;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: table of instructions with their expected
// state paths, a per-cycle scoreboard of expected state/control words, plus
// hand-written reset-in-MEM, counter-wrap and HALT sequences.
module tb_mc_ctrl_fsm;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] OP_NOP   = 6'b010101;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic        ab_write;
  logic        aluout_write;
  logic        mdr_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        mem_read;
  logic        mem_write;
  logic        iord;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] instr_cnt;

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .ab_write(ab_write),
    .aluout_write(aluout_write), .mdr_write(mdr_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .state(state), .halted(halted), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [5:0]       op;
    logic             z;
    int               wif;
    int               wmem;
    int               n;
    logic [4:0][2:0]  path;
  } vec_t;

  typedef struct {
    logic [2:0]  st;
    logic [19:0] ctl;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[12];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt;
  int          ncyc;

  // Control word: {pc_write, pc_src, ir_write, ab_write, aluout_write, mdr_write,
  // alu_src_a, alu_src_b, alu_op, mem_read, mem_write, iord, reg_write, reg_dst,
  // mem_to_reg, halted}
  function automatic logic [19:0] ctl_now();
    return {pc_write, pc_src, ir_write, ab_write, aluout_write, mdr_write,
            alu_src_a, alu_src_b, alu_op, mem_read, mem_write, iord,
            reg_write, reg_dst, mem_to_reg, halted};
  endfunction

  // Expected control word for a state, written from the controller's output table.
  function automatic logic [19:0] exp_ctl(input logic [2:0] st, input logic [5:0] o,
                                          input logic z, input logic rdy);
    logic pcw, irw, abw, aow, mdrw, asa, mr, mw, io, rw, rd, m2r, h;
    logic [1:0] pcs, asb, aop;
    {pcw, irw, abw, aow, mdrw, asa, mr, mw, io, rw, rd, m2r, h} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      3'd0: begin
        mr = 1'b1; asb = 2'b01;
        if (rdy) begin irw = 1'b1; pcw = 1'b1; end
      end
      3'd1: begin
        abw = 1'b1; aow = 1'b1; asb = 2'b11;
        if (o == OP_J) begin pcw = 1'b1; pcs = 2'b10; end
      end
      3'd2: begin
        asa = 1'b1; aow = 1'b1;
        if (o == OP_RTYPE) aop = 2'b10;
        else if (o == OP_ADDI || o == OP_LW || o == OP_SW) asb = 2'b10;
        else if (o == OP_BEQ) begin aop = 2'b01; aow = 1'b0; pcw = z; pcs = 2'b01; end
      end
      3'd3: begin
        io = 1'b1;
        if (o == OP_LW) begin mr = 1'b1; mdrw = rdy; end
        if (o == OP_SW) mw = 1'b1;
      end
      3'd4: begin
        rw = 1'b1; rd = (o == OP_RTYPE); m2r = (o == OP_LW);
      end
      3'd5: h = 1'b1;
      default: ;
    endcase
    return {pcw, pcs, irw, abw, aow, mdrw, asa, asb, aop, mr, mw, io, rw, rd, m2r, h};
  endfunction

  function automatic vec_t mk(input string nm, input logic [5:0] o, input logic z,
                              input int wif, input int wmem, input int n,
                              input logic [2:0] s0, input logic [2:0] s1,
                              input logic [2:0] s2, input logic [2:0] s3,
                              input logic [2:0] s4);
    vec_t v;
    v.name = nm; v.op = o; v.z = z; v.wif = wif; v.wmem = wmem; v.n = n;
    v.path[0] = s0; v.path[1] = s1; v.path[2] = s2; v.path[3] = s3; v.path[4] = s4;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    end
  endtask

  // One clock of stimulus: push expectation when driving, pop and compare at negedge.
  task automatic cycle(input logic [2:0] est, input logic rdy);
    exp_t e;
    mem_ready = rdy;
    e.st  = est;
    e.ctl = exp_ctl(est, op, zero, rdy);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check("state", {29'd0, state}, {29'd0, e.st});
    check("ctl", {12'd0, ctl_now()}, {12'd0, e.ctl});
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic run(input vec_t v);
    logic [2:0] s;
    op = v.op; zero = v.z; ncyc = 0;
    for (int i = 0; i < v.n; i++) begin
      s = v.path[i];
      if (s == 3'd0) begin
        repeat (v.wif) cycle(3'd0, 1'b0);
        cycle(3'd0, 1'b1);
      end else if (s == 3'd3) begin
        repeat (v.wmem) cycle(3'd3, 1'b0);
        cycle(3'd3, 1'b1);
      end else begin
        cycle(s, 1'($urandom_range(0, 1)));
      end
    end
    exp_cnt = exp_cnt + 32'd1;
    check("instr_cnt", instr_cnt, exp_cnt);
    $display("instr %-10s op=%b zero=%0d cycles=%0d instr_cnt=%0h", v.name, v.op, v.z, ncyc, instr_cnt);
  endtask

  initial begin
    vecs[0]  = mk("addi",     OP_ADDI,  1'b0, 0, 0, 4, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0);
    vecs[1]  = mk("rtype",    OP_RTYPE, 1'b0, 0, 0, 4, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0);
    vecs[2]  = mk("lw",       OP_LW,    1'b0, 0, 0, 5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4);
    vecs[3]  = mk("sw",       OP_SW,    1'b0, 0, 0, 4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0);
    vecs[4]  = mk("beq_z1",   OP_BEQ,   1'b1, 0, 0, 3, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0);
    vecs[5]  = mk("beq_z0",   OP_BEQ,   1'b0, 0, 0, 3, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0);
    vecs[6]  = mk("lw_wait3", OP_LW,    1'b0, 0, 3, 5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4);
    vecs[7]  = mk("nop",      OP_NOP,   1'b0, 0, 0, 2, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0);
    vecs[8]  = mk("j",        OP_J,     1'b0, 0, 0, 2, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0);
    vecs[9]  = mk("addi_if2", OP_ADDI,  1'b0, 2, 0, 4, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0);
    vecs[10] = mk("sw_wait",  OP_SW,    1'b0, 1, 2, 4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0);
    vecs[11] = mk("rtype_z1", OP_RTYPE, 1'b1, 0, 0, 4, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0);

    // Power-up reset.
    reset = 1'b1; op = OP_LW; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", {12'd0, ctl_now()}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_state", {29'd0, state}, 32'd0);
    check("reset_cnt", instr_cnt, 32'd0);
    exp_cnt = 32'd0;

    // Table-driven instruction sequence.
    for (int k = 0; k < 12; k++) run(vecs[k]);

    // Reset while an LW waits in MEM: strobes silenced, instruction aborted.
    op = OP_LW; zero = 1'b0;
    cycle(3'd0, 1'b1);
    cycle(3'd1, 1'b1);
    cycle(3'd2, 1'b1);
    cycle(3'd3, 1'b0);
    reset = 1'b1;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_mem_state", {29'd0, state}, (k == 0) ? 32'd3 : 32'd0);
      check("rst_mem_ctl", {12'd0, ctl_now()}, 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    check("rst_mem_state_after", {29'd0, state}, 32'd0);
    check("rst_mem_cnt_after", instr_cnt, 32'd0);
    $display("instr reset_in_mem instr_cnt=%0h state=%0d", instr_cnt, state);
    exp_cnt = 32'd0;

    // Counter wrap: preload all-ones while IF stalls, then retire a J.
    op = OP_J; mem_ready = 1'b0;
    force dut.instr_cnt_reg = 32'hFFFF_FFFF;
    #2;
    release dut.instr_cnt_reg;
    #1;
    check("wrap_preload", instr_cnt, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check("wrap_hold", instr_cnt, 32'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    run(vecs[8]);

    // HALT: sticky, counter frozen, only reset exits.
    op = OP_HALT; zero = 1'b0; ncyc = 0;
    cycle(3'd0, 1'b1);
    cycle(3'd1, 1'b1);
    for (int k = 0; k < 6; k++) cycle(3'd5, 1'($urandom_range(0, 1)));
    check("halt_cnt", instr_cnt, exp_cnt);
    $display("instr halt       op=%b cycles=%0d instr_cnt=%0h halted=%0d", op, ncyc, instr_cnt, halted);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("halt_exit_state", {29'd0, state}, 32'd0);
    check("halt_exit_halted", {31'd0, halted}, 32'd0);
    exp_cnt = 32'd0;
    run(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
